// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter between NUM_REQ requesters.
// Define UART_TX_ARB_FIXED_PRIO_EN for fixed priority (lowest req index wins).
module uart_tx_arbiter #(
   parameter int unsigned NUM_REQ      = 4,
   parameter int unsigned CLKS_PER_BIT = 10416,
   parameter int unsigned FRAME_BITS   = 13
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NUM_REQ-1:0]   req,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   grant,
   output logic                 tx_transmit,
   output logic [7:0]           tx_data,
   output logic                 busy
);

   localparam int unsigned FRAME_CLKS = FRAME_BITS * CLKS_PER_BIT;
   localparam int unsigned TMR_W      = $clog2(FRAME_CLKS);
   localparam int unsigned PTR_W      = $clog2(NUM_REQ);
   localparam int unsigned SUM_W      = PTR_W + 1;
   localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(CLKS_PER_BIT);
   localparam logic [TMR_W-1:0] FRAME_LAST = TMR_W'(FRAME_CLKS - 1);
   localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {IDLE, HOLD, WAIT} state_t;

   state_t               state_q, state_d;
   logic [TMR_W-1:0]     timer_q, timer_d;
   logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [NUM_REQ-1:0]   grant_q, grant_d;
   logic                 tx_transmit_q, tx_transmit_d;
   logic [7:0]           tx_data_q, tx_data_d;
   logic                 busy_q, busy_d;

   logic                 found;
   logic [PTR_W-1:0]     winner;
   logic [SUM_W-1:0]     idx;

   // Winner search: first set req bit from the search start, wrapping modulo NUM_REQ
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
`ifdef UART_TX_ARB_FIXED_PRIO_EN
         idx = SUM_W'(i);
`else
         idx = {1'b0, rr_ptr_q} + SUM_W'(i);
         if (idx >= SUM_W'(NUM_REQ)) begin
            idx = idx - SUM_W'(NUM_REQ);
         end
`endif
         if (!found && req[idx[PTR_W-1:0]]) begin
            found  = 1'b1;
            winner = idx[PTR_W-1:0];
         end
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d       = state_q;
      timer_d       = timer_q;
      rr_ptr_d      = rr_ptr_q;
      grant_d       = '0;
      tx_transmit_d = tx_transmit_q;
      tx_data_d     = tx_data_q;
      busy_d        = busy_q;
      case (state_q)
         IDLE: begin
            if (found) begin
               grant_d       = NUM_REQ'(1) << winner;
               tx_data_d     = req_data[{winner, 3'b000} +: 8];
`ifdef UART_TX_ARB_FIXED_PRIO_EN
               rr_ptr_d      = '0;
`else
               rr_ptr_d      = (winner == PTR_LAST) ? '0 : winner + PTR_W'(1);
`endif
               timer_d       = '0;
               tx_transmit_d = 1'b1;
               busy_d        = 1'b1;
               state_d       = HOLD;
            end
         end
         HOLD: begin
            timer_d = timer_q + TMR_W'(1);
            if (timer_q == HOLD_LAST) begin
               tx_transmit_d = 1'b0;
               state_d       = WAIT;
            end
         end
         WAIT: begin
            timer_d = timer_q + TMR_W'(1);
            if (timer_q == FRAME_LAST) begin
               timer_d   = '0;
               busy_d    = 1'b0;
               tx_data_d = '0;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= IDLE;
         timer_q       <= '0;
         rr_ptr_q      <= '0;
         grant_q       <= '0;
         tx_transmit_q <= 1'b0;
         tx_data_q     <= '0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         timer_q       <= timer_d;
         rr_ptr_q      <= rr_ptr_d;
         grant_q       <= grant_d;
         tx_transmit_q <= tx_transmit_d;
         tx_data_q     <= tx_data_d;
         busy_q        <= busy_d;
      end
   end

   assign grant       = grant_q;
   assign tx_transmit = tx_transmit_q;
   assign tx_data     = tx_data_q;
   assign busy        = busy_q;

endmodule
